axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
AXI4-Lite initiator that converts a single-outstanding CPU-side request/response interface (IFU/LSU) into AXI4-Lite AR/R or AW/W/B transactions. It drives the memory/peripheral responders on the bus and returns read data or write completion with an error flag. There is exactly one transaction in flight at a time; there is no reordering and no bursts.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; STRB_W = DATA_W/8

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  master can accept request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
req_wstrb  in  STRB_W  write byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  CPU accepts response
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  1 when RRESP/BRESP != OKAY
araddr  out  ADDR_W  AR address
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  DATA_W  R data
rresp  in  2  R response
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  ADDR_W  AW address
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  DATA_W  W data
wstrb  out  STRB_W  W strobes
wvalid  out  1  W valid
wready  in  1  W ready
bresp  in  2  B response
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- Reset (rst_n low, async): state=IDLE; arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err = 0; rsp_rdata = 0; latched addr/data/strb = 0. req_ready = 1 once reset deasserts.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, RESP.
- IDLE: req_ready=1 (combinational decode of state==IDLE only). On req_valid&req_ready, latch addr/wdata/wstrb/we.
  - Read: next RD_A with arvalid=1.
  - Write: next WR_AW with awvalid=1 and wvalid=1 asserted in the same cycle; aw_done=w_done=0.
- RD_A: hold arvalid and a stable araddr until arvalid&arready. Then arvalid=0, rready=1, go to RD_D.
- RD_D: on rvalid&rready, capture rsp_rdata=rdata and rsp_err=(rresp!=OKAY). Then rready=0, rsp_valid=1, go to RESP.
- WR_AW: each channel drops its valid on its own handshake and sets aw_done/w_done.
  - When both handshakes have completed (same or different cycles), go to WR_B with bready=1.
  - Payload stays stable while valid is held.
- WR_B: on bvalid&bready, rsp_rdata=0, rsp_err=(bresp!=OKAY), bready=0, rsp_valid=1, go to RESP.
- RESP: hold rsp_valid/rsp_rdata/rsp_err stable until rsp_ready. Then rsp_valid=0 and return to IDLE.
- Latency with zero-wait responder:
  - Read: accept at cycle 0, arvalid at 1, rready at 2, rsp_valid at 3.
  - Write: aw/w at 1, bready at 2, rsp_valid at 3.
- A new request is accepted no earlier than the cycle after the response handshake.
- Never deassert a valid before its handshake. Never assert rready or bready outside RD_D or WR_B.
- SLVERR/DECERR: data is still returned and rsp_err=1. There is no retry.
- rst_n asserted mid-transaction: immediate return to IDLE and all valids cleared. The bus partner is reset by the same signal.
- Addresses and strobes pass through unmodified. There is no alignment check.

Decomposition:
- Package axi_lite_pkg holds:
  - resp codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the master state enum;
  - default ADDR_W/DATA_W constants.
- Single module; no sub-module needed.

Test Plan:
1. Read 0x80000004, responder arready after 3 cycles, rdata=0xDEADBEEF, rresp=00 -> one AR handshake at araddr=0x80000004; rsp_valid with rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Write 0x80000010, wdata=0x12345678, wstrb=0x3; awready at cycle 1, wready at cycle 4 -> awvalid drops after cycle 1; wvalid is held until cycle 4; bready only after both; rsp_err=0, rsp_rdata=0.
3. Read with rresp=SLVERR, rdata=0xA5A5A5A5 -> rsp_err=1, rsp_rdata=0xA5A5A5A5. Write with bresp=DECERR -> rsp_err=1.
4. rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable for 5 cycles; req_ready stays 0; no AXI valids asserted.
5. Back-to-back read-write-read with req_valid held high -> three transactions in order; each new AR/AW appears only after the previous response handshake.
6. rst_n pulsed low while in RD_D -> arvalid/rready/rsp_valid go 0 asynchronously; after release req_ready=1 and the next read completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite response codes, master state encoding and default widths
package axi_lite_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_AW = 3'd3,
        ST_WR_B  = 3'd4,
        ST_RESP  = 3'd5
    } master_state_e;

endpackage

// File: rtl/axi_lite_master_if.sv
// rtl/axi_lite_master_if.sv - AXI4-Lite AR/R/AW/W/B channel bundle
// master modport: drives araddr/arvalid/rready/awaddr/awvalid/wdata/wstrb/wvalid/bready
// slave modport : drives arready/rdata/rresp/rvalid/awready/wready/bresp/bvalid
interface axi_lite_master_if
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) ();
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding CPU request/response to AXI4-Lite initiator
// clk, rst_n          : clock, asynchronous active-low reset
// req_* (valid/ready) : CPU request: we, addr, wdata, wstrb
// rsp_* (valid/ready) : CPU response: rdata (0 for writes), err (resp != OKAY)
// m_axi               : AXI4-Lite master channels
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    axi_lite_master_if.master m_axi
);
    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] RD_A  = ST_RD_A;
    localparam logic [2:0] RD_D  = ST_RD_D;
    localparam logic [2:0] WR_AW = ST_WR_AW;
    localparam logic [2:0] WR_B  = ST_WR_B;
    localparam logic [2:0] RESP  = ST_RESP;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              arvalid_q;
    logic              rready_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;
    logic              aw_done;
    logic              w_done;

    logic aw_fire;
    logic w_fire;

    // Payload comes straight from the latched request, so it cannot move while a valid is held.
    assign m_axi.araddr  = addr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;

    assign req_ready = (state == IDLE);

    assign aw_fire = awvalid_q & m_axi.awready;
    assign w_fire  = wvalid_q & m_axi.wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        if (req_we) begin
                            state     <= WR_AW;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                        end else begin
                            state     <= RD_A;
                            arvalid_q <= 1'b1;
                        end
                    end
                end

                RD_A: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_D;
                    end
                end

                RD_D: begin
                    if (m_axi.rvalid) begin
                        rsp_rdata <= m_axi.rdata;
                        rsp_err   <= (m_axi.rresp != RESP_OKAY);
                        rready_q  <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end

                WR_AW: begin
                    // AW and W complete independently; the done flags remember an early one.
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done | aw_fire) && (w_done | w_fire)) begin
                        bready_q <= 1'b1;
                        state    <= WR_B;
                    end
                end

                WR_B: begin
                    if (m_axi.bvalid) begin
                        rsp_rdata <= '0;
                        rsp_err   <= (m_axi.bresp != RESP_OKAY);
                        bready_q  <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - scoreboard bench for axi_lite_master with a configurable AXI responder
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    axi_lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m_axi     (bus.master)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // responder configuration
    int          ar_delay = 0, aw_delay = 0, w_delay = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = RESP_OKAY, cfg_bresp = RESP_OKAY;
    bit          data_from_addr = 0;
    bit          r_stall = 0;

    // responder state and monitors
    int          ar_cnt, aw_cnt, w_cnt;
    bit          r_pend, r_fire, b_pend, b_fire, aw_got, w_got;
    logic [31:0] r_data_q;
    int          ar_hs, aw_hs, w_hs, aw_hi, w_hi, bready_early, overlap;
    logic [31:0] last_araddr, last_awaddr, last_wdata;
    logic [3:0]  last_wstrb;

    function automatic logic [31:0] addr_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic clear_mon();
        ar_hs = 0; aw_hs = 0; w_hs = 0; aw_hi = 0; w_hi = 0;
        bready_early = 0; overlap = 0;
        last_araddr = '0; last_awaddr = '0; last_wdata = '0; last_wstrb = '0;
    endtask

    // Responder: all decisions at the falling edge, seen by the DUT at the next rising edge.
    initial begin
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        r_pend = 0; r_fire = 0; b_pend = 0; b_fire = 0; aw_got = 0; w_got = 0;
        r_data_q = '0;
        clear_mon();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.arready = 0; bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
                r_pend = 0; r_fire = 0; b_pend = 0; b_fire = 0; aw_got = 0; w_got = 0;
            end else begin
                bit aw_now, w_now;
                if (rsp_valid && (bus.arvalid || bus.awvalid || bus.wvalid ||
                                  bus.rready || bus.bready || req_ready))
                    overlap++;

                if (r_fire) begin bus.rvalid = 0; r_fire = 0; end
                if (r_pend && !r_stall) begin
                    bus.rvalid = 1; bus.rdata = r_data_q; bus.rresp = cfg_rresp;
                    if (bus.rready) begin r_pend = 0; r_fire = 1; end
                end

                if (bus.arvalid) begin
                    bus.arready = (ar_cnt >= ar_delay);
                    ar_cnt++;
                    if (bus.arready) begin
                        ar_hs++;
                        last_araddr = bus.araddr;
                        r_data_q = data_from_addr ? addr_data(bus.araddr) : cfg_rdata;
                        r_pend = 1;
                    end
                end else begin
                    bus.arready = 0; ar_cnt = 0;
                end

                if (b_fire) begin bus.bvalid = 0; b_fire = 0; end
                if (bus.bready && !(aw_got && w_got)) bready_early++;
                if (b_pend) begin
                    bus.bvalid = 1; bus.bresp = cfg_bresp;
                    if (bus.bready) begin b_pend = 0; b_fire = 1; aw_got = 0; w_got = 0; end
                end

                aw_now = 0; w_now = 0;
                if (bus.awvalid) begin
                    aw_hi++;
                    bus.awready = (aw_cnt >= aw_delay);
                    aw_cnt++;
                    if (bus.awready) begin aw_hs++; last_awaddr = bus.awaddr; aw_got = 1; aw_now = 1; end
                end else begin
                    bus.awready = 0; aw_cnt = 0;
                end
                if (bus.wvalid) begin
                    w_hi++;
                    bus.wready = (w_cnt >= w_delay);
                    w_cnt++;
                    if (bus.wready) begin
                        w_hs++; last_wdata = bus.wdata; last_wstrb = bus.wstrb; w_got = 1; w_now = 1;
                    end
                end else begin
                    bus.wready = 0; w_cnt = 0;
                end
                if ((aw_now || w_now) && aw_got && w_got) b_pend = 1;
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input bit hold, output bit ok);
        req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st; req_valid = 1; ok = 0;
        for (int n = 0; n < 200; n++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        if (!hold) req_valid = 0;
    endtask

    task automatic wait_rsp(output logic [31:0] d, output logic e, output int waited, output bit ok);
        ok = 0; waited = 0; d = '0; e = 0;
        rsp_ready = 0;
        for (int n = 0; n < 300; n++) begin
            if (rsp_valid) begin ok = 1; break; end
            @(negedge clk);
            waited++;
        end
        if (ok) begin
            d = rsp_rdata; e = rsp_err;
            rsp_ready = 1;
            @(negedge clk);
            rsp_ready = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        @(negedge clk);
        total++;
        if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, rsp_valid, rsp_err} !== 7'b0) begin
            bad++; $display("FAIL reset_valids got=%b exp=0000000",
                {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, rsp_valid, rsp_err});
        end
        total++;
        if (rsp_rdata !== 32'h0 || bus.araddr !== 32'h0 || bus.wdata !== 32'h0 || bus.wstrb !== 4'h0) begin
            bad++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h wstrb=%h exp all zero",
                rsp_rdata, bus.araddr, bus.wdata, bus.wstrb);
        end
        rst_n = 1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_read_wait();
        bit ok; logic [31:0] d; logic e; int w; exp_t x;
        clear_mon(); ar_delay = 3; data_from_addr = 0; cfg_rdata = 32'hDEADBEEF; cfg_rresp = RESP_OKAY;
        sb.push_back('{32'hDEADBEEF, 1'b0});
        do_req(1'b0, 32'h8000_0004, 32'h0, 4'h0, 0, ok);
        wait_rsp(d, e, w, ok);
        x = sb.pop_front();
        total++;
        if (!ok) begin bad++; $display("FAIL rd_wait_timeout got=no_rsp exp=rsp"); end
        total++;
        if (d !== x.rdata || e !== x.err) begin
            bad++; $display("FAIL rd_wait_rsp got=%h/%b exp=%h/%b", d, e, x.rdata, x.err);
        end
        total++;
        if (ar_hs !== 1 || last_araddr !== 32'h8000_0004) begin
            bad++; $display("FAIL rd_wait_ar got hs=%0d addr=%h exp hs=1 addr=80000004", ar_hs, last_araddr);
        end
        ar_delay = 0;
    endtask

    task automatic test_write_split();
        bit ok; logic [31:0] d; logic e; int w; exp_t x;
        clear_mon(); aw_delay = 0; w_delay = 3; cfg_bresp = RESP_OKAY;
        sb.push_back('{32'h0, 1'b0});
        do_req(1'b1, 32'h8000_0010, 32'h1234_5678, 4'h3, 0, ok);
        wait_rsp(d, e, w, ok);
        x = sb.pop_front();
        total++;
        if (!ok || d !== x.rdata || e !== x.err) begin
            bad++; $display("FAIL wr_split_rsp got ok=%b %h/%b exp=%h/%b", ok, d, e, x.rdata, x.err);
        end
        total++;
        if (aw_hi !== 1 || w_hi !== 4) begin
            bad++; $display("FAIL wr_split_valid_cycles got aw=%0d w=%0d exp aw=1 w=4", aw_hi, w_hi);
        end
        total++;
        if (bready_early !== 0) begin bad++; $display("FAIL wr_split_bready_early got=%0d exp=0", bready_early); end
        total++;
        if (aw_hs !== 1 || w_hs !== 1 || last_awaddr !== 32'h8000_0010 ||
            last_wdata !== 32'h1234_5678 || last_wstrb !== 4'h3) begin
            bad++; $display("FAIL wr_split_payload got hs=%0d/%0d addr=%h data=%h strb=%h exp 1/1 80000010 12345678 3",
                aw_hs, w_hs, last_awaddr, last_wdata, last_wstrb);
        end
        w_delay = 0;
    endtask

    task automatic test_errors();
        bit ok; logic [31:0] d; logic e; int w; exp_t x;
        clear_mon(); cfg_rdata = 32'hA5A5A5A5; cfg_rresp = RESP_SLVERR;
        sb.push_back('{32'hA5A5A5A5, 1'b1});
        do_req(1'b0, 32'h0000_1000, 32'h0, 4'h0, 0, ok);
        wait_rsp(d, e, w, ok);
        x = sb.pop_front();
        total++;
        if (!ok || d !== x.rdata || e !== x.err) begin
            bad++; $display("FAIL rd_slverr got ok=%b %h/%b exp=%h/%b", ok, d, e, x.rdata, x.err);
        end
        total++;
        if (w !== 2) begin bad++; $display("FAIL rd_latency got=%0d exp=2", w); end
        cfg_rresp = RESP_OKAY;

        cfg_bresp = RESP_DECERR;
        sb.push_back('{32'h0, 1'b1});
        do_req(1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'hF, 0, ok);
        wait_rsp(d, e, w, ok);
        x = sb.pop_front();
        total++;
        if (!ok || d !== x.rdata || e !== x.err) begin
            bad++; $display("FAIL wr_decerr got ok=%b %h/%b exp=%h/%b", ok, d, e, x.rdata, x.err);
        end
        total++;
        if (w !== 2) begin bad++; $display("FAIL wr_latency got=%0d exp=2", w); end
        cfg_bresp = RESP_OKAY;
    endtask

    task automatic test_backpressure();
        bit ok, seen; logic [31:0] d; logic e; int w; exp_t x;
        clear_mon(); cfg_rdata = 32'h0BAD_F00D;
        sb.push_back('{32'h0BAD_F00D, 1'b0});
        do_req(1'b0, 32'h0000_3000, 32'h0, 4'h0, 0, ok);
        seen = 0;
        for (int n = 0; n < 50; n++) begin
            if (rsp_valid) begin seen = 1; break; end
            @(negedge clk);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL bp_timeout got=no_rsp exp=rsp"); end
        for (int c = 0; c < 5; c++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D || req_ready !== 1'b0 ||
                bus.arvalid || bus.awvalid || bus.wvalid || bus.rready || bus.bready) begin
                bad++; $display("FAIL bp_hold cycle=%0d got valid=%b rdata=%h req_ready=%b exp 1 0badf00d 0",
                    c, rsp_valid, rsp_rdata, req_ready);
            end
            @(negedge clk);
        end
        wait_rsp(d, e, w, ok);
        x = sb.pop_front();
        total++;
        if (!ok || d !== x.rdata || e !== x.err) begin
            bad++; $display("FAIL bp_rsp got ok=%b %h/%b exp=%h/%b", ok, d, e, x.rdata, x.err);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon(); data_from_addr = 1;
        fork
            begin
                bit ok;
                sb.push_back('{addr_data(32'h0000_00A0), 1'b0});
                do_req(1'b0, 32'h0000_00A0, 32'h0, 4'h0, 1, ok);
                total++;
                if (!ok) begin bad++; $display("FAIL b2b_req0 got=timeout exp=accept"); end
                sb.push_back('{32'h0, 1'b0});
                do_req(1'b1, 32'h0000_00B0, 32'h5555_AAAA, 4'hC, 1, ok);
                total++;
                if (!ok) begin bad++; $display("FAIL b2b_req1 got=timeout exp=accept"); end
                sb.push_back('{addr_data(32'h0000_00C4), 1'b0});
                do_req(1'b0, 32'h0000_00C4, 32'h0, 4'h0, 0, ok);
                total++;
                if (!ok) begin bad++; $display("FAIL b2b_req2 got=timeout exp=accept"); end
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    bit ok; logic [31:0] d; logic e; int w; exp_t x;
                    wait_rsp(d, e, w, ok);
                    total++;
                    if (!ok || sb.size() == 0) begin
                        bad++; $display("FAIL b2b_rsp%0d got=timeout exp=rsp", k);
                    end else begin
                        x = sb.pop_front();
                        if (d !== x.rdata || e !== x.err) begin
                            bad++; $display("FAIL b2b_rsp%0d got=%h/%b exp=%h/%b", k, d, e, x.rdata, x.err);
                        end
                    end
                end
            end
        join
        total++;
        if (ar_hs !== 2 || aw_hs !== 1 || last_awaddr !== 32'h0000_00B0 || last_wstrb !== 4'hC) begin
            bad++; $display("FAIL b2b_counts got ar=%0d aw=%0d awaddr=%h strb=%h exp 2 1 000000b0 c",
                ar_hs, aw_hs, last_awaddr, last_wstrb);
        end
        total++;
        if (overlap !== 0) begin bad++; $display("FAIL b2b_overlap got=%0d exp=0", overlap); end
        data_from_addr = 0;
    endtask

    task automatic test_reset_mid();
        bit ok, seen; logic [31:0] d; logic e; int w; exp_t x;
        clear_mon(); r_stall = 1;
        do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, ok);
        seen = 0;
        for (int n = 0; n < 50; n++) begin
            if (bus.rready) begin seen = 1; break; end
            @(negedge clk);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL rstmid_rd_d got=no_rready exp=rready"); end
        #2 rst_n = 0;
        #1;
        total++;
        if ({bus.arvalid, bus.rready, rsp_valid, bus.awvalid, bus.wvalid, bus.bready} !== 6'b0) begin
            bad++; $display("FAIL rstmid_async got=%b exp=000000",
                {bus.arvalid, bus.rready, rsp_valid, bus.awvalid, bus.wvalid, bus.bready});
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        r_stall = 0;
        rst_n = 1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_req_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        cfg_rdata = 32'h7777_0001;
        sb.push_back('{32'h7777_0001, 1'b0});
        do_req(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, ok);
        wait_rsp(d, e, w, ok);
        x = sb.pop_front();
        total++;
        if (!ok || d !== x.rdata || e !== x.err || last_araddr !== 32'h0000_0044) begin
            bad++; $display("FAIL rstmid_next_read got ok=%b %h/%b addr=%h exp=%h/%b addr=00000044",
                ok, d, e, last_araddr, x.rdata, x.err);
        end
    endtask

    initial begin
        test_reset();
        test_read_wait();
        test_write_split();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
